// File: rtl/playback.sv
// S/PDIF playback: fetches 32-bit subframe words over an MCB-style read port,
// adds even parity and biphase-mark encodes each subframe onto tos_out.
module playback #(
    parameter int ADDR_STEP = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cell_ce,
    output logic        tos_out,
    input  logic [31:0] frames,
    input  logic [29:0] base_addr,
    input  logic        start,
    output logic [31:0] frames_remaining,
    output logic        done,
    output logic        underrun,
    output logic        cmd_clk,
    output logic        cmd_en,
    output logic [2:0]  cmd_instr,
    output logic [5:0]  cmd_bl,
    output logic [29:0] cmd_byte_addr,
    input  logic        cmd_full,
    output logic        rd_clk,
    output logic        rd_en,
    input  logic [31:0] rd_data,
    input  logic        rd_empty
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT_DATA = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam logic [1:0] PRE_B = 2'd0;
    localparam logic [1:0] PRE_M = 2'd1;
    localparam logic [1:0] PRE_W = 2'd2;

    logic [1:0]  state;
    logic [29:0] addr;
    logic        hold_full;
    logic [30:4] hold_payload;
    logic [1:0]  hold_pre;

    logic        ser_active;
    logic [5:0]  cell_cnt;
    logic [5:0]  cell_next;
    logic [31:4] sub_data;
    logic [7:0]  sub_pre;
    logic [1:0]  last_pre;

    logic [31:4] next_data;
    logic [1:0]  next_type;
    logic [7:0]  next_pat;

    logic start_ok, sub_end, load, filler;
    logic unused_bits;

    assign cmd_clk       = clock;
    assign rd_clk        = clock;
    assign cmd_instr     = 3'b001;
    assign cmd_bl        = 6'd0;
    assign cmd_en        = (state == S_ISSUE) && !cmd_full;
    assign rd_en         = (state == S_WAIT_DATA) && !rd_empty;
    assign cmd_byte_addr = addr;
    assign done          = (frames_remaining == 32'd0) && !ser_active;
    assign unused_bits   = ^{rd_data[31], rd_data[3:2]};

    assign start_ok  = (state == S_IDLE) && start;
    assign sub_end   = cell_ce && ser_active && (cell_cnt == 6'd63);
    assign load      = cell_ce && (!ser_active || cell_cnt == 6'd63) && hold_full;
    assign filler    = sub_end && !hold_full && (frames_remaining != 32'd0);
    assign cell_next = cell_cnt + 6'd1;

    // Next subframe: the held word, or a V=1 filler that keeps the B/M/W rhythm.
    always_comb begin
        next_data = {1'b0, 3'b001, 24'd0};
        next_type = (last_pre == PRE_M) ? PRE_W : PRE_M;
        if (hold_full) begin
            next_data = {1'b0, hold_payload};
            case (hold_pre)
                2'b00:   next_type = PRE_B;
                2'b10:   next_type = PRE_W;
                default: next_type = PRE_M;
            endcase
        end
        next_data[31] = ^next_data[30:4];
        case (next_type)
            PRE_B:   next_pat = 8'b11101000;
            PRE_W:   next_pat = 8'b11100100;
            default: next_pat = 8'b11100010;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            addr             <= '0;
            frames_remaining <= '0;
            underrun         <= 1'b0;
            hold_full        <= 1'b0;
        end else begin
            if (start_ok)    underrun <= 1'b0;
            else if (filler) underrun <= 1'b1;

            if (start_ok)  frames_remaining <= frames;
            else if (load) frames_remaining <= frames_remaining - 32'd1;

            if (rd_en)     hold_full <= 1'b1;
            else if (load) hold_full <= 1'b0;

            case (state)
                S_IDLE: if (start) begin
                    addr <= base_addr;
                    if (frames != 32'd0) state <= S_ISSUE;
                end
                S_ISSUE: if (!cmd_full) begin
                    addr  <= addr + 30'(ADDR_STEP);
                    state <= S_WAIT_DATA;
                end
                S_WAIT_DATA: if (!rd_empty) state <= S_HOLD;
                default: if (load) state <= (frames_remaining != 32'd1) ? S_ISSUE : S_IDLE;
            endcase
        end
    end

    // NOTE: the word payload carries no reset; hold_full alone says whether it is valid.
    always_ff @(posedge clock) begin
        if (rd_en) begin
            hold_payload <= rd_data[30:4];
            hold_pre     <= rd_data[1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tos_out    <= 1'b0;
            ser_active <= 1'b0;
            cell_cnt   <= '0;
            sub_data   <= '0;
            sub_pre    <= '0;
            last_pre   <= PRE_B;
        end else if (load || filler) begin
            // Preamble polarity follows the line level just before cell 0.
            sub_data   <= next_data;
            sub_pre    <= next_pat ^ {8{tos_out}};
            tos_out    <= next_pat[7] ^ tos_out;
            cell_cnt   <= 6'd0;
            ser_active <= 1'b1;
            last_pre   <= next_type;
        end else if (cell_ce && ser_active) begin
            if (cell_cnt == 6'd63) begin
                ser_active <= 1'b0;
            end else begin
                cell_cnt <= cell_next;
                if (cell_next < 6'd8)  tos_out <= sub_pre[~cell_next[2:0]];
                else if (!cell_next[0]) tos_out <= ~tos_out;
                else                    tos_out <= tos_out ^ sub_data[cell_next[5:1]];
            end
        end
    end

endmodule
